// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave is the unit's view; master is the requester plus memory.
interface load_store_unit_if #(
  parameter int BITS = 32
);
  logic            reqValid;
  logic            reqReady;
  logic            reqWrite;
  logic [1:0]      reqSize;
  logic            reqSigned;
  logic [BITS-1:0] reqAddress;
  logic [BITS-1:0] reqWriteData;
  logic            respValid;
  logic [BITS-1:0] respData;
  logic            respError;
  logic [BITS-1:0] memAddress;
  logic [BITS-1:0] memWriteData;
  logic            memEnableRead;
  logic            memEnableWrite;
  logic [BITS-1:0] memReadData;

  modport slave (
    input  reqValid,
    output reqReady,
    input  reqWrite,
    input  reqSize,
    input  reqSigned,
    input  reqAddress,
    input  reqWriteData,
    output respValid,
    output respData,
    output respError,
    output memAddress,
    output memWriteData,
    output memEnableRead,
    output memEnableWrite,
    input  memReadData
  );

  modport master (
    output reqValid,
    input  reqReady,
    output reqWrite,
    output reqSize,
    output reqSigned,
    output reqAddress,
    output reqWriteData,
    input  respValid,
    input  respData,
    input  respError,
    input  memAddress,
    input  memWriteData,
    input  memEnableRead,
    input  memEnableWrite,
    output memReadData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access to a word-wide
// data memory, sub-word stores by read-modify-write.
module load_store_unit #(
  parameter int BITS = 32
) (
  input  logic clk,
  input  logic reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    ERROR,
    DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic [BITS-1:0] merge_q, merge_d;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            rd_en, wr_en;
  logic            ready, accept, bad;
  logic [BITS-1:0] mem_addr, mem_wdata;
  logic [4:0]      shamt;
  logic [BITS-1:0] rd_shift;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] ins_mask;
  logic [BITS-1:0] ins_data;
  logic [BITS-1:0] merged;

  assign accept = bus.reqValid & ready;

  always_comb begin
    bad = 1'b0;
    unique case (bus.reqSize)
      SZ_HALF: bad = bus.reqAddress[0];
      SZ_WORD: bad = |bus.reqAddress[1:0];
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  assign shamt    = {addr_q[1:0], 3'b000};
  assign rd_shift = bus.memReadData >> shamt;
  assign lane_b   = rd_shift[7:0];
  assign lane_h   = rd_shift[15:0];

  always_comb begin
    load_val = bus.memReadData;
    unique case (size_q)
      SZ_BYTE: load_val = sign_q
        ? {{(BITS-8){lane_b[7]}}, lane_b}
        : {{(BITS-8){1'b0}}, lane_b};
      SZ_HALF: load_val = sign_q
        ? {{(BITS-16){lane_h[15]}}, lane_h}
        : {{(BITS-16){1'b0}}, lane_h};
      default: load_val = bus.memReadData;
    endcase
  end

  // Lane mask and store data moved into the addressed lane.
  always_comb begin
    if (size_q == SZ_BYTE) begin
      ins_mask = BITS'(32'h0000_00ff) << shamt;
    end else begin
      ins_mask = BITS'(32'h0000_ffff) << shamt;
    end
    ins_data = wdata_q << shamt;
    merged   = (bus.memReadData & ~ins_mask)
             | (ins_data & ins_mask);
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    sign_d    = sign_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ready     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          write_d = bus.reqWrite;
          size_d  = bus.reqSize;
          sign_d  = bus.reqSigned;
          addr_d  = bus.reqAddress;
          wdata_d = bus.reqWriteData;
          rdata_d = '0;
          err_d   = 1'b0;
          unique case (1'b1)
            bad:
              state_d = ERROR;
            !bad && !bus.reqWrite:
              state_d = LOAD;
            !bad && bus.reqWrite &&
            (bus.reqSize == SZ_WORD):
              state_d = WRITE;
            !bad && bus.reqWrite &&
            (bus.reqSize != SZ_WORD):
              state_d = RMW_READ;
            default:
              state_d = ERROR;
          endcase
        end
      end
      LOAD: begin
        rd_en    = 1'b1;
        mem_addr = {2'b00, addr_q[BITS-1:2]};
        rdata_d  = load_val;
        state_d  = DONE;
      end
      RMW_READ: begin
        rd_en    = 1'b1;
        mem_addr = {2'b00, addr_q[BITS-1:2]};
        merge_d  = merged;
        state_d  = WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        mem_addr  = {2'b00, addr_q[BITS-1:2]};
        mem_wdata = (size_q == SZ_WORD)
                  ? wdata_q : merge_q;
        state_d   = DONE;
      end
      ERROR: begin
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Enables are gated by reset so an aborted RMW never writes.
  assign bus.memEnableRead  = rd_en & ~reset;
  assign bus.memEnableWrite = wr_en & ~reset;
  assign bus.memAddress     = mem_addr;
  assign bus.memWriteData   = mem_wdata;
  assign bus.reqReady       = ready;
  assign bus.respValid      = (state_q == DONE);
  assign bus.respData       = rdata_q;
  assign bus.respError      = err_q;

endmodule
